// File: rtl/sd_bd_queue.sv
// Buffer-descriptor queue manager for the SD DMA controller: NUM_CH descriptor FIFOs
// loaded over a Wishbone slave window, popped by the data master, with per-channel IRQs.
module sd_bd_queue #(
    parameter int NUM_CH   = 2,
    parameter int BD_DEPTH = 8,
    parameter int ADR_W    = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic [7:0]        wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic              wb_ack_o,
    output logic [NUM_CH-1:0] bd_avail_o,
    input  logic              pop_i,
    input  logic [3:0]        pop_ch_i,
    output logic              pop_vld_o,
    output logic [ADR_W-1:0]  pop_sys_adr_o,
    output logic [ADR_W-1:0]  pop_card_adr_o,
    input  logic              cmp_i,
    input  logic [3:0]        cmp_ch_i,
    input  logic              cmp_err_i,
    output logic              int_o
);

    localparam int PW = (BD_DEPTH > 1) ? $clog2(BD_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(BD_DEPTH);
    localparam logic [4:0]    NUM_CH_C = 5'(NUM_CH);

    localparam logic [3:0] OFF_PUSH   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_ISR    = 4'h8;
    localparam logic [3:0] OFF_ISER   = 4'hC;

    logic [ADR_W-1:0] sys_mem   [NUM_CH][BD_DEPTH];
    logic [ADR_W-1:0] card_mem  [NUM_CH][BD_DEPTH];
    logic [PW-1:0]    head      [NUM_CH];
    logic [PW-1:0]    tail      [NUM_CH];
    logic [CW-1:0]    used      [NUM_CH];
    logic             stage_vld [NUM_CH];
    logic [ADR_W-1:0] stage_sys [NUM_CH];
    logic [3:0]       isr       [NUM_CH];
    logic [3:0]       iser      [NUM_CH];

    logic             wb_req;
    logic             wb_wr;
    logic             ch_ok;
    logic [3:0]       wb_ch;
    logic [3:0]       wb_off;
    logic [ADR_W-1:0] wr_adr;
    logic [31:0]      rd_data;
    logic [ADR_W-1:0] pop_sys_nxt;
    logic [ADR_W-1:0] pop_card_nxt;
    logic             irq_any;

    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] first_wr;
    logic [NUM_CH-1:0] commit_ok;
    logic [NUM_CH-1:0] overflow;
    logic [NUM_CH-1:0] flush;
    logic [NUM_CH-1:0] isr_wr;
    logic [NUM_CH-1:0] iser_wr;
    logic [NUM_CH-1:0] pop_ok;
    logic [NUM_CH-1:0] drained;
    logic [NUM_CH-1:0] cmp_hit;

    assign wb_ch  = wb_adr_i[7:4];
    assign wb_off = wb_adr_i[3:0];
    assign ch_ok  = {1'b0, wb_ch} < NUM_CH_C;
    assign wb_req = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wb_wr  = wb_req & wb_we_i & ch_ok;
    assign wr_adr = ADR_W'(wb_dat_i);

    // Per-channel events; a pop only sees entries committed on earlier edges.
    always_comb begin
        sel       = '0;
        first_wr  = '0;
        commit_ok = '0;
        overflow  = '0;
        flush     = '0;
        isr_wr    = '0;
        iser_wr   = '0;
        pop_ok    = '0;
        drained   = '0;
        cmp_hit   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sel[c]       = wb_wr && (wb_ch == 4'(c));
            first_wr[c]  = sel[c] && (wb_off == OFF_PUSH) && !stage_vld[c];
            commit_ok[c] = sel[c] && (wb_off == OFF_PUSH) && stage_vld[c] && (used[c] != DEPTH_C);
            overflow[c]  = sel[c] && (wb_off == OFF_PUSH) && stage_vld[c] && (used[c] == DEPTH_C);
            flush[c]     = sel[c] && (wb_off == OFF_STATUS) && wb_dat_i[0];
            isr_wr[c]    = sel[c] && (wb_off == OFF_ISR);
            iser_wr[c]   = sel[c] && (wb_off == OFF_ISER);
            pop_ok[c]    = pop_i && (pop_ch_i == 4'(c)) && (used[c] != '0);
            drained[c]   = pop_ok[c] && (used[c] == CW'(1)) && !commit_ok[c];
            cmp_hit[c]   = cmp_i && (cmp_ch_i == 4'(c));
        end
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wb_ch == 4'(c)) begin
                case (wb_off)
                    OFF_STATUS: rd_data = {15'd0, stage_vld[c], 8'(used[c]), 8'(DEPTH_C - used[c])};
                    OFF_ISR:    rd_data = {28'd0, isr[c]};
                    OFF_ISER:   rd_data = {28'd0, iser[c]};
                    default:    rd_data = '0;
                endcase
            end
        end
    end

    always_comb begin
        pop_sys_nxt  = '0;
        pop_card_nxt = '0;
        irq_any      = 1'b0;
        bd_avail_o   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pop_ok[c]) begin
                pop_sys_nxt  = sys_mem[c][head[c]];
                pop_card_nxt = card_mem[c][head[c]];
            end
            irq_any       = irq_any | (|(isr[c] & iser[c]));
            bd_avail_o[c] = (used[c] != '0);
        end
    end

    // Descriptor storage is never reset; the pointers define which entries are live.
    always_ff @(posedge wb_clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (commit_ok[c]) begin
                sys_mem[c][tail[c]]  <= stage_sys[c];
                card_mem[c][tail[c]] <= wr_adr;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            wb_ack_o       <= 1'b0;
            wb_dat_o       <= '0;
            pop_vld_o      <= 1'b0;
            pop_sys_adr_o  <= '0;
            pop_card_adr_o <= '0;
            int_o          <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                head[c]      <= '0;
                tail[c]      <= '0;
                used[c]      <= '0;
                stage_vld[c] <= 1'b0;
                stage_sys[c] <= '0;
                isr[c]       <= '0;
                iser[c]      <= '0;
            end
        end else begin
            wb_ack_o  <= wb_req;
            wb_dat_o  <= (wb_req && !wb_we_i) ? rd_data : '0;
            pop_vld_o <= |pop_ok;
            int_o     <= irq_any;
            if (|pop_ok) begin
                pop_sys_adr_o  <= pop_sys_nxt;
                pop_card_adr_o <= pop_card_nxt;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (first_wr[c]) begin
                    stage_sys[c] <= wr_adr;
                    stage_vld[c] <= 1'b1;
                end
                if (commit_ok[c] || overflow[c]) begin
                    stage_vld[c] <= 1'b0;
                end
                if (flush[c]) begin
                    head[c]      <= '0;
                    tail[c]      <= '0;
                    used[c]      <= '0;
                    stage_vld[c] <= 1'b0;
                end else begin
                    if (pop_ok[c]) begin
                        head[c] <= head[c] + PW'(1);
                    end
                    if (commit_ok[c]) begin
                        tail[c] <= tail[c] + PW'(1);
                    end
                    case ({commit_ok[c], pop_ok[c]})
                        2'b10:   used[c] <= used[c] + CW'(1);
                        2'b01:   used[c] <= used[c] - CW'(1);
                        default: used[c] <= used[c];
                    endcase
                end
                // New events are ORed in after the W1C mask so a same-cycle set wins.
                isr[c] <= (isr[c] & ~(isr_wr[c] ? wb_dat_i[3:0] : 4'h0))
                        | {drained[c], overflow[c], cmp_hit[c] & cmp_err_i, cmp_hit[c]};
                if (iser_wr[c]) begin
                    iser[c] <= wb_dat_i[3:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_bd_queue.sv
// Self-checking bench for sd_bd_queue: register vector table, directed corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_sd_bd_queue;

    localparam logic [3:0] OFF_PUSH   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_ISR    = 4'h8;
    localparam logic [3:0] OFF_ISER   = 4'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [31:0] wb_dat_o;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_ack;
    logic [1:0]  bd_avail;
    logic        pop = 1'b0;
    logic [3:0]  pop_ch = '0;
    logic        pop_vld;
    logic [31:0] pop_sys;
    logic [31:0] pop_card;
    logic        cmp = 1'b0;
    logic [3:0]  cmp_ch = '0;
    logic        cmp_err = 1'b0;
    logic        int_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sd_bd_queue #(.NUM_CH(2), .BD_DEPTH(8), .ADR_W(32)) dut (
        .wb_clk_i       (clk),
        .wb_rst_n_i     (rst_n),
        .wb_adr_i       (wb_adr),
        .wb_dat_i       (wb_dat),
        .wb_dat_o       (wb_dat_o),
        .wb_we_i        (wb_we),
        .wb_cyc_i       (wb_cyc),
        .wb_stb_i       (wb_stb),
        .wb_ack_o       (wb_ack),
        .bd_avail_o     (bd_avail),
        .pop_i          (pop),
        .pop_ch_i       (pop_ch),
        .pop_vld_o      (pop_vld),
        .pop_sys_adr_o  (pop_sys),
        .pop_card_adr_o (pop_card),
        .cmp_i          (cmp),
        .cmp_ch_i       (cmp_ch),
        .cmp_err_i      (cmp_err),
        .int_o          (int_o)
    );

    typedef struct {
        string       name;
        bit          we;
        logic [3:0]  ch;
        logic [3:0]  off;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic [1:0]  exp_avail;
    } vec_t;

    vec_t vecs[$];

    // Reference model: one FIFO of {sys, card} per channel plus staging and IRQ state.
    logic [63:0] mq [2][$];
    bit          m_stg [2];
    logic [31:0] m_stg_sys [2];
    logic [3:0]  m_isr [2];
    logic [3:0]  m_iser [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic wbAccess(input bit we, input logic [3:0] ch, input logic [3:0] off,
                            input logic [31:0] data, input bit do_pop, input logic [3:0] pch,
                            input bit do_cmp, input logic [3:0] cch, input bit cerr,
                            output logic [31:0] rd, output logic pv,
                            output logic [31:0] ps, output logic [31:0] pcd);
        int n;
        wb_adr  = {ch, off};
        wb_dat  = data;
        wb_we   = we;
        wb_cyc  = 1'b1;
        wb_stb  = 1'b1;
        pop     = do_pop;
        pop_ch  = pch;
        cmp     = do_cmp;
        cmp_ch  = cch;
        cmp_err = cerr;
        tick();
        pop     = 1'b0;
        cmp     = 1'b0;
        cmp_err = 1'b0;
        pv      = pop_vld;
        ps      = pop_sys;
        pcd     = pop_card;
        n = 1;
        while (!wb_ack && n < 4) begin
            tick();
            n++;
        end
        checkOutput("wb_ack", 32'(wb_ack), 32'd1);
        rd = wb_dat_o;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        tick();
        checkOutput("wb_ack_single", 32'(wb_ack), 32'd0);
    endtask

    task automatic wbWrite(input logic [3:0] ch, input logic [3:0] off, input logic [31:0] data);
        logic [31:0] rd, ps, pcd;
        logic pv;
        wbAccess(1'b1, ch, off, data, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, rd, pv, ps, pcd);
    endtask

    task automatic wbRead(input logic [3:0] ch, input logic [3:0] off, output logic [31:0] rd);
        logic [31:0] ps, pcd;
        logic pv;
        wbAccess(1'b0, ch, off, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, rd, pv, ps, pcd);
    endtask

    task automatic readCheck(input string name, input logic [3:0] ch, input logic [3:0] off,
                             input logic [31:0] exp);
        logic [31:0] rd;
        wbRead(ch, off, rd);
        checkOutput(name, rd, exp);
    endtask

    task automatic popOnce(input logic [3:0] pch, output logic pv, output logic [31:0] ps,
                           output logic [31:0] pcd);
        pop    = 1'b1;
        pop_ch = pch;
        tick();
        pop = 1'b0;
        pv  = pop_vld;
        ps  = pop_sys;
        pcd = pop_card;
    endtask

    task automatic cmpOnce(input logic [3:0] cch, input bit cerr);
        cmp     = 1'b1;
        cmp_ch  = cch;
        cmp_err = cerr;
        tick();
        cmp     = 1'b0;
        cmp_err = 1'b0;
    endtask

    task automatic doReset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] rd, ps, pcd;
        logic pv;
        wbAccess(v.we, v.ch, v.off, v.data, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, rd, pv, ps, pcd);
        if (!v.we) checkOutput(v.name, rd, v.exp_rd);
        checkOutput({v.name, "_avail"}, 32'(bd_avail), 32'(v.exp_avail));
    endtask

    task automatic modelPush(input int c, input logic [31:0] d, input int pre_size,
                             output bit committed);
        committed = 1'b0;
        if (!m_stg[c]) begin
            m_stg[c]     = 1'b1;
            m_stg_sys[c] = d;
        end else begin
            m_stg[c] = 1'b0;
            if (pre_size >= 8) begin
                m_isr[c] = m_isr[c] | 4'h4;
            end else begin
                mq[c].push_back({m_stg_sys[c], d});
                committed = 1'b1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd, ps, pcd, d, exp_rd;
        logic [63:0] e;
        logic        pv;
        bit          exp_pv, committed;
        int          op, rch, pc, pre, sz;
        logic [31:0] ref_sys [$];
        logic [31:0] ref_card [$];

        doReset(2);
        checkOutput("rst_avail", 32'(bd_avail), 32'd0);
        checkOutput("rst_int", 32'(int_o), 32'd0);
        checkOutput("rst_pop_vld", 32'(pop_vld), 32'd0);

        vecs.push_back('{"rst_status",     1'b0, 4'd0, OFF_STATUS, 32'h0,        32'h0000_0008, 2'b00});
        vecs.push_back('{"rst_isr",        1'b0, 4'd0, OFF_ISR,    32'h0,        32'h0,         2'b00});
        vecs.push_back('{"ch1_push_sys",   1'b1, 4'd1, OFF_PUSH,   32'h1000_0000, 32'h0,        2'b00});
        vecs.push_back('{"ch1_staged",     1'b0, 4'd1, OFF_STATUS, 32'h0,        32'h0001_0008, 2'b00});
        vecs.push_back('{"ch1_push_card",  1'b1, 4'd1, OFF_PUSH,   32'h0000_0040, 32'h0,        2'b10});
        vecs.push_back('{"ch1_status",     1'b0, 4'd1, OFF_STATUS, 32'h0,        32'h0000_0107, 2'b10});
        vecs.push_back('{"ch1_push_rd0",   1'b0, 4'd1, OFF_PUSH,   32'h0,        32'h0,         2'b10});
        vecs.push_back('{"ch2_status",     1'b0, 4'd2, OFF_STATUS, 32'h0,        32'h0,         2'b10});
        vecs.push_back('{"ch2_iser_wr",    1'b1, 4'd2, OFF_ISER,   32'hF,        32'h0,         2'b10});
        vecs.push_back('{"ch2_iser_rd",    1'b0, 4'd2, OFF_ISER,   32'h0,        32'h0,         2'b10});
        vecs.push_back('{"ch0_iser_wr",    1'b1, 4'd0, OFF_ISER,   32'h5,        32'h0,         2'b10});
        vecs.push_back('{"ch0_iser_rd",    1'b0, 4'd0, OFF_ISER,   32'h0,        32'h5,         2'b10});
        vecs.push_back('{"ch0_unmapped",   1'b0, 4'd0, 4'h2,       32'h0,        32'h0,         2'b10});
        vecs.push_back('{"ch0_iser_clr",   1'b1, 4'd0, OFF_ISER,   32'h0,        32'h0,         2'b10});
        vecs.push_back('{"ch1_isr_rd",     1'b0, 4'd1, OFF_ISR,    32'h0,        32'h0,         2'b10});
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

        // Single pop on ch1, then ignored pops on an empty and an invalid channel.
        popOnce(4'd1, pv, ps, pcd);
        checkOutput("pop1_vld", 32'(pv), 32'd1);
        checkOutput("pop1_sys", ps, 32'h1000_0000);
        checkOutput("pop1_card", pcd, 32'h0000_0040);
        tick();
        checkOutput("pop1_pulse_end", 32'(pop_vld), 32'd0);
        checkOutput("pop1_sys_hold", pop_sys, 32'h1000_0000);
        checkOutput("pop1_avail", 32'(bd_avail), 32'd0);
        readCheck("pop1_isr_drained", 4'd1, OFF_ISR, 32'h8);
        popOnce(4'd1, pv, ps, pcd);
        checkOutput("pop_empty_vld", 32'(pv), 32'd0);
        popOnce(4'd5, pv, ps, pcd);
        checkOutput("pop_badch_vld", 32'(pv), 32'd0);
        wbWrite(4'd1, OFF_ISR, 32'hF);
        readCheck("ch1_isr_cleared", 4'd1, OFF_ISR, 32'h0);

        // Overflow on the ninth commit, then drain in order.
        for (int i = 0; i < 9; i++) begin
            wbWrite(4'd0, OFF_PUSH, 32'hA000_0000 + 32'(i));
            wbWrite(4'd0, OFF_PUSH, 32'(i * 16));
        end
        readCheck("ovf_status", 4'd0, OFF_STATUS, 32'h0000_0800);
        readCheck("ovf_isr", 4'd0, OFF_ISR, 32'h4);
        checkOutput("ovf_avail", 32'(bd_avail), 32'h1);
        for (int i = 0; i < 8; i++) begin
            popOnce(4'd0, pv, ps, pcd);
            checkOutput("drain_vld", 32'(pv), 32'd1);
            checkOutput("drain_sys", ps, 32'hA000_0000 + 32'(i));
            checkOutput("drain_card", pcd, 32'(i * 16));
        end
        tick();
        checkOutput("drain_avail", 32'(bd_avail), 32'h0);
        readCheck("drain_isr", 4'd0, OFF_ISR, 32'hC);
        wbWrite(4'd0, OFF_ISR, 32'hF);

        // Interrupt path, W1C, and set-wins when W1C coincides with completion.
        wbWrite(4'd0, OFF_ISER, 32'h3);
        checkOutput("irq_idle", 32'(int_o), 32'd0);
        cmpOnce(4'd0, 1'b1);
        checkOutput("irq_not_yet", 32'(int_o), 32'd0);
        tick();
        checkOutput("irq_raised", 32'(int_o), 32'd1);
        readCheck("irq_isr", 4'd0, OFF_ISR, 32'h3);
        wbWrite(4'd0, OFF_ISR, 32'h3);
        checkOutput("irq_cleared", 32'(int_o), 32'd0);
        cmpOnce(4'd0, 1'b1);
        tick();
        wbAccess(1'b1, 4'd0, OFF_ISR, 32'h3, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, rd, pv, ps, pcd);
        readCheck("set_wins_isr", 4'd0, OFF_ISR, 32'h3);
        checkOutput("set_wins_int", 32'(int_o), 32'd1);
        wbWrite(4'd0, OFF_ISR, 32'hF);
        cmpOnce(4'd0, 1'b0);
        readCheck("cmp_noerr_isr", 4'd0, OFF_ISR, 32'h1);
        wbWrite(4'd0, OFF_ISR, 32'hF);
        wbWrite(4'd0, OFF_ISER, 32'h0);

        // Pointer wrap with commit and pop on the same edge at used = 4.
        ref_sys.delete();
        ref_card.delete();
        for (int k = 0; k < 4; k++) begin
            wbWrite(4'd0, OFF_PUSH, 32'hB000_0000 + 32'(k));
            wbWrite(4'd0, OFF_PUSH, 32'(k));
            ref_sys.push_back(32'hB000_0000 + 32'(k));
            ref_card.push_back(32'(k));
        end
        for (int k = 4; k < 16; k++) begin
            wbWrite(4'd0, OFF_PUSH, 32'hB000_0000 + 32'(k));
            wbAccess(1'b1, 4'd0, OFF_PUSH, 32'(k), 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, rd, pv, ps, pcd);
            checkOutput("wrap_vld", 32'(pv), 32'd1);
            checkOutput("wrap_sys", ps, ref_sys.pop_front());
            checkOutput("wrap_card", pcd, ref_card.pop_front());
            ref_sys.push_back(32'hB000_0000 + 32'(k));
            ref_card.push_back(32'(k));
            readCheck("wrap_status", 4'd0, OFF_STATUS, 32'h0000_0404);
        end
        for (int k = 0; k < 4; k++) begin
            popOnce(4'd0, pv, ps, pcd);
            checkOutput("wrap_drain_sys", ps, ref_sys.pop_front());
            checkOutput("wrap_drain_card", pcd, ref_card.pop_front());
        end
        tick();
        checkOutput("wrap_avail", 32'(bd_avail), 32'h0);

        // Reset discards a half-written descriptor.
        wbWrite(4'd0, OFF_PUSH, 32'hDEAD_0000);
        readCheck("half_staged", 4'd0, OFF_STATUS, 32'h0001_0008);
        doReset(1);
        readCheck("half_reset", 4'd0, OFF_STATUS, 32'h0000_0008);
        wbWrite(4'd0, OFF_PUSH, 32'h0000_0123);
        readCheck("half_restart", 4'd0, OFF_STATUS, 32'h0001_0008);
        wbWrite(4'd0, OFF_PUSH, 32'h0000_0456);

        // Flush a full queue; ISR is untouched.
        for (int i = 0; i < 8; i++) begin
            wbWrite(4'd0, OFF_PUSH, 32'hC000_0000 + 32'(i));
            wbWrite(4'd0, OFF_PUSH, 32'(i));
        end
        readCheck("flush_pre", 4'd0, OFF_STATUS, 32'h0000_0800);
        readCheck("flush_pre_isr", 4'd0, OFF_ISR, 32'h4);
        wbWrite(4'd0, OFF_STATUS, 32'h1);
        readCheck("flush_status", 4'd0, OFF_STATUS, 32'h0000_0008);
        readCheck("flush_isr", 4'd0, OFF_ISR, 32'h4);
        checkOutput("flush_avail", 32'(bd_avail), 32'h0);

        // Randomized traffic against the reference model.
        doReset(2);
        for (int c = 0; c < 2; c++) begin
            mq[c].delete();
            m_stg[c]     = 1'b0;
            m_stg_sys[c] = '0;
            m_isr[c]     = '0;
            m_iser[c]    = '0;
        end
        for (int it = 0; it < 400; it++) begin
            op  = $urandom_range(0, 7);
            rch = $urandom_range(0, 2);
            d   = $urandom;
            case (op)
                0, 1: begin
                    wbWrite(4'(rch), OFF_PUSH, d);
                    if (rch < 2) modelPush(rch, d, mq[rch].size(), committed);
                end
                2: begin
                    pc = $urandom_range(0, 3);
                    popOnce(4'(pc), pv, ps, pcd);
                    exp_pv = (pc < 2) && (mq[pc].size() > 0);
                    checkOutput("rnd_pop_vld", 32'(pv), 32'(exp_pv));
                    if (exp_pv) begin
                        e = mq[pc].pop_front();
                        checkOutput("rnd_pop_sys", ps, e[63:32]);
                        checkOutput("rnd_pop_card", pcd, e[31:0]);
                        if (mq[pc].size() == 0) m_isr[pc] = m_isr[pc] | 4'h8;
                    end
                end
                3: begin
                    pc = $urandom_range(0, 3);
                    exp_pv = bit'($urandom_range(0, 1));
                    cmpOnce(4'(pc), exp_pv);
                    if (pc < 2) m_isr[pc] = m_isr[pc] | {2'b00, exp_pv, 1'b1};
                end
                4: begin
                    sz = (rch < 2) ? mq[rch].size() : 0;
                    exp_rd = (rch < 2) ? {15'd0, m_stg[rch], 8'(sz), 8'(8 - sz)} : 32'd0;
                    readCheck("rnd_status", 4'(rch), OFF_STATUS, exp_rd);
                end
                5: begin
                    readCheck("rnd_isr", 4'(rch), OFF_ISR, (rch < 2) ? {28'd0, m_isr[rch]} : 32'd0);
                    d = 32'($urandom_range(0, 15));
                    wbWrite(4'(rch), OFF_ISR, d);
                    if (rch < 2) m_isr[rch] = m_isr[rch] & ~d[3:0];
                end
                6: begin
                    d = 32'($urandom_range(0, 15));
                    wbWrite(4'(rch), OFF_ISER, d);
                    if (rch < 2) m_iser[rch] = d[3:0];
                end
                default: begin
                    pre = (rch < 2) ? mq[rch].size() : 0;
                    wbAccess(1'b1, 4'(rch), OFF_PUSH, d, 1'b1, 4'(rch), 1'b0, 4'd0, 1'b0,
                             rd, pv, ps, pcd);
                    exp_pv = (rch < 2) && (pre > 0);
                    checkOutput("rnd_cpop_vld", 32'(pv), 32'(exp_pv));
                    if (exp_pv) begin
                        e = mq[rch].pop_front();
                        checkOutput("rnd_cpop_sys", ps, e[63:32]);
                        checkOutput("rnd_cpop_card", pcd, e[31:0]);
                    end
                    if (rch < 2) begin
                        modelPush(rch, d, pre, committed);
                        if (exp_pv && pre == 1 && !committed) m_isr[rch] = m_isr[rch] | 4'h8;
                    end
                end
            endcase
            tick();
            checkOutput("rnd_avail", 32'(bd_avail),
                        32'({mq[1].size() > 0, mq[0].size() > 0}));
            checkOutput("rnd_int", 32'(int_o),
                        32'((|(m_isr[0] & m_iser[0])) | (|(m_isr[1] & m_iser[1]))));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
